apb_cmd_master: RTL

- Simple-command-to-APB master bridge. Sits directly upstream of the APB SRAM slave interface and drives its psel/penable/paddr/pwrite/pwdata.
- Accepts one valid/ready command (read or write) at a time and runs the APB SETUP→ACCESS sequence.
- Waits for pready, then returns read data/status on a valid/ready response channel.
- Exactly one transaction outstanding at any time.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_cmd_master.sv | 138 +++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Constants shared by the APB command master and the APB SRAM slave
// interface.
//   APB_ADDR_W / APB_DATA_W : default APB byte-address and data widths.
//   apb_state_e              : 2-bit transfer-phase encoding
//                              IDLE=0, SETUP=1, ACCESS=2, RESP=3.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
// Bridges a simple valid/ready command channel onto an APB master port and
// returns read data / status on a valid/ready response channel. Exactly one
// transaction is in flight at a time: IDLE -> SETUP -> ACCESS -> RESP.
//
// Ports
//   clk, rstn          : clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    : command handshake; ready is high only in IDLE
//   cmd_write/addr/wdata: command payload (addr is a byte address)
//   rsp_valid/ready    : response handshake
//   rsp_rdata, rsp_err : read data (0 for writes), abort status
//   psel, penable, paddr, pwrite, pwdata : APB request signals
//   pready, prdata     : APB completion / read data, used only in ACCESS
//
// Optional feature (compile-time macro APB_TIMEOUT_EN):
//   When defined, an ACCESS phase that sees pready=0 for TIMEOUT_CYC cycles
//   is aborted and answered with rsp_err=1, rsp_rdata=0. When undefined the
//   master waits for pready indefinitely and rsp_err is tied to 0.
// ---------------------------------------------------------------------------
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  // The timeout counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("apb_cmd_master: TIMEOUT_CYC must be in 1..255");
  end

  // Clears the two byte-lane bits so every APB access is word aligned.
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  apb_state_e state;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  // Gated with rstn so the command side reads as not-ready while reset is
  // asserted even though the state register already sits at IDLE.
  assign cmd_ready = rstn && (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr & WORD_MASK;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            psel   <= 1'b1;
            state  <= SETUP;
`ifdef APB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // pready has priority over the timeout on the same edge.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
`ifdef APB_TIMEOUT_EN
            rsp_err   <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
`endif
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
